instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction-memory byte address width (depth 2**ADDR_W = 512).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port byte_len  input  ADDR_W+1  payload byte count, sampled when start is accepted.
REQ-006 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1) for the byte-stream source.
REQ-007 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, 8), the instruction-memory write port.
REQ-008 SHALL have port cpu_hold  output  1  drives PC LE low and holds the pipeline registers in reset while high.
REQ-009 SHALL have ports done (output, 1) and error (output, 1), the load status flags.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, CHECK, DONE and ERR.
REQ-011 SHALL in IDLE go to LOAD on start when 1 <= byte_len <= 2**ADDR_W, and to ERR on start otherwise.
REQ-012 SHALL on entry to LOAD clear the byte counter and the checksum accumulator, and latch byte_len.
REQ-013 SHALL drive in_ready=1 only in LOAD and CHECK, and accept a byte only on a cycle where in_valid && in_ready.
REQ-014 SHALL, for each byte accepted in LOAD, register mem_we=1, mem_addr=counter[ADDR_W-1:0] and mem_wdata=in_data on the next cycle (1-cycle latency), then increment the counter.
REQ-015 SHALL hold mem_we=0 on every cycle that follows a cycle with no accepted LOAD byte.
REQ-016 SHALL leave LOAD when the accepted count equals latched byte_len; the final byte write still occurs on the following cycle.
REQ-017 SHALL NOT increment mem_addr past 2**ADDR_W-1, because the count never exceeds 2**ADDR_W.
REQ-018 SHALL assert cpu_hold=1 in IDLE, LOAD, CHECK and ERR, and deassert it only in DONE.
REQ-019 SHALL hold done=1 only in DONE and error=1 only in ERR.
REQ-020 SHALL ignore start while in LOAD or CHECK.
REQ-021 SHALL treat start in DONE or ERR as start in IDLE, with the same length check and with done/error cleared on the same edge.
REQ-022 SHALL freeze the counter while in_valid=0 in LOAD, with no timeout.
REQ-023 SHALL accumulate an 8-bit modulo-256 sum of the payload bytes.

Reset
REQ-024 SHALL, while Reset=0, force state=IDLE, counter=0, sum=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, done=0, error=0 and cpu_hold=1, independent of clk.
REQ-025 SHALL, when Reset asserts mid-LOAD, abort the load without any further mem_we; bytes already written remain in memory.

Configuration
REQ-026 SHALL, with LOADER_CHECKSUM_EN defined, go from LOAD to CHECK after the last payload byte.
REQ-027 SHALL in CHECK accept one checksum byte without writing memory, then go to DONE if (sum + byte) mod 256 == 0 and to ERR otherwise.
REQ-028 SHALL, without LOADER_CHECKSUM_EN, go from LOAD directly to DONE, exclude CHECK and the accumulator from synthesis, and keep the port list unchanged.

Verification
REQ-029 SHALL cover: reset, start with byte_len=4, stream 0x13,0x05,0x50,0x00 with in_valid always high -> mem_we on 4 consecutive cycles at addresses 0..3 with matching data; DONE one cycle after the last write; cpu_hold falls with done.
REQ-030 SHALL cover: byte_len=3 with in_valid low for 5 cycles between bytes 1 and 2 -> no write during the gap, addresses 0,1,2 written in order, counter never skips.
REQ-031 SHALL cover: start with byte_len=0 and, separately, byte_len=513 -> ERR on the next cycle, error=1, no mem_we, cpu_hold stays 1.
REQ-032 SHALL cover: byte_len=512 with a full stream -> last write at mem_addr=511, no write at any wrapped address, then DONE.
REQ-033 SHALL cover: Reset pulled low after 2 of 6 bytes -> all outputs at reset values asynchronously; a new start with byte_len=2 rewrites addresses 0 and 1.
REQ-034 SHALL cover, with LOADER_CHECKSUM_EN: payload 0x10,0x20 plus checksum 0xD0 -> DONE; checksum 0xD1 -> ERR; in both cases exactly 2 writes occur.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Streams a byte payload into instruction memory while holding the CPU in reset.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W:0]   byte_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERR} state_t;
`endif

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic len_in_range(input logic [ADDR_W:0] len);
    return (len != '0) && (len <= MAX_LEN);
  endfunction

  state_t          state, next_state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] len_q;
  logic            accept;
  logic            load_acc;
  logic            start_acc;

  assign accept    = in_valid && in_ready;
  assign load_acc  = accept && (state == LOAD);
  assign start_acc = start && ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  logic [7:0] sum;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sum <= '0;
    end else if (start_acc && len_in_range(byte_len)) begin
      sum <= '0;
    end else if (load_acc) begin
      sum <= add_mod256(sum, in_data);
    end
  end
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The exit test uses the post-increment count, so the final write is seen
  // one cycle before the state leaves LOAD and no extra byte is taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        in_ready = (count != len_q);
        if (count == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (accept) begin
          next_state = (add_mod256(sum, in_data) == 8'h00) ? DONE : ERR;
        end
      end
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR: error = 1'b1;
      default: next_state = IDLE;
    endcase
    if (start_acc) begin
      next_state = len_in_range(byte_len) ? LOAD : ERR;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
      len_q <= '0;
    end else if (start_acc && len_in_range(byte_len)) begin
      count <= '0;
      len_q <= byte_len;
    end else if (load_acc) begin
      count <= count + 1'b1;
    end
  end

  // Write port stage: one cycle behind the accepted byte.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= load_acc;
      if (load_acc) begin
        mem_addr  <= count[ADDR_W-1:0];
        mem_wdata <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; write port checked by a queue-based monitor.
module tb_instr_mem_loader;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              Reset;
  logic              start;
  logic [ADDR_W:0]   byte_len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  int last_addr = -1;
  logic [16:0] exp_q[$];

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .Reset(Reset), .start(start), .byte_len(byte_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [16:0] e;
      writes++;
      last_addr = int'(mem_addr);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_wdata, e[16:8], e[7:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [ADDR_W:0] len);
    start = 1'b1;
    byte_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte: in_ready never seen for 0x%0h, expected 1", b);
    end
  endtask

  task automatic wait_status(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (done || error) seen = 1'b1;
    end
    check({name, "_status_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({9'(a), d});
  endtask

  initial begin
    int w0;
    Reset = 1'b0; start = 1'b0; byte_len = '0; in_valid = 1'b0; in_data = '0;
    #3;
    check("rst_we", 32'(mem_we), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;

    // Basic 4-byte load, contiguous stream
    w0 = writes;
    push(0, 8'h13); push(1, 8'h05); push(2, 8'h50); push(3, 8'h00);
    do_start(10'd4);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    check("a_last_we", 32'(mem_we), 1);
    check("a_done_early", 32'(done), 0);
    check("a_hold_early", 32'(cpu_hold), 1);
    @(negedge clk);
    check("a_done", 32'(done), 1);
    check("a_hold", 32'(cpu_hold), 0);
    check("a_we_after", 32'(mem_we), 0);
    check("a_writes", 32'(writes - w0), 4);

    // Stalled stream: in_valid low for 5 cycles between bytes
    w0 = writes;
    push(0, 8'hA1); push(1, 8'hB2); push(2, 8'hC3);
    do_start(10'd3);
    check("b_done_cleared", 32'(done), 0);
    send_byte(8'hA1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check("b_gap_we", 32'(mem_we), 0);
      @(posedge clk); #1;
    end
    send_byte(8'hB2); send_byte(8'hC3);
    in_valid = 1'b0;
    wait_status("b");
    check("b_done", 32'(done), 1);
    check("b_writes", 32'(writes - w0), 3);
    check("b_last_addr", 32'(last_addr), 2);

    // Out-of-range lengths
    w0 = writes;
    do_start(10'd0);
    @(negedge clk);
    check("c0_error", 32'(error), 1);
    check("c0_done", 32'(done), 0);
    check("c0_hold", 32'(cpu_hold), 1);
    check("c0_ready", 32'(in_ready), 0);
    do_start(10'd513);
    @(negedge clk);
    check("c513_error", 32'(error), 1);
    check("c513_hold", 32'(cpu_hold), 1);
    @(negedge clk);
    check("c_writes", 32'(writes - w0), 0);

    // Full-depth load
    w0 = writes;
    for (int i = 0; i < 512; i++) push(i, 8'(i * 7 + 3));
    do_start(10'd512);
    check("d_error_cleared", 32'(error), 0);
    for (int i = 0; i < 512; i++) send_byte(8'(i * 7 + 3));
    in_valid = 1'b0;
    wait_status("d");
    check("d_done", 32'(done), 1);
    check("d_writes", 32'(writes - w0), 512);
    check("d_last_addr", 32'(last_addr), 511);
    @(negedge clk);
    check("d_queue_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of a load
    w0 = writes;
    push(0, 8'h11); push(1, 8'h22);
    do_start(10'd6);
    send_byte(8'h11); send_byte(8'h22);
    in_valid = 1'b0;
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check("e_rst_we", 32'(mem_we), 0);
    check("e_rst_addr", 32'(mem_addr), 0);
    check("e_rst_wdata", 32'(mem_wdata), 0);
    check("e_rst_ready", 32'(in_ready), 0);
    check("e_rst_hold", 32'(cpu_hold), 1);
    check("e_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    check("e_writes_before", 32'(writes - w0), 2);
    push(0, 8'hAA); push(1, 8'hBB);
    do_start(10'd2);
    send_byte(8'hAA); send_byte(8'hBB);
    in_valid = 1'b0;
    wait_status("e");
    check("e_done", 32'(done), 1);
    check("e_writes", 32'(writes - w0), 4);

`ifdef LOADER_CHECKSUM_EN
    // Checksum accepted, then rejected
    w0 = writes;
    push(0, 8'h10); push(1, 8'h20);
    do_start(10'd2);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD0);
    in_valid = 1'b0;
    wait_status("f_ok");
    check("f_ok_done", 32'(done), 1);
    check("f_ok_error", 32'(error), 0);
    check("f_ok_writes", 32'(writes - w0), 2);
    w0 = writes;
    push(0, 8'h10); push(1, 8'h20);
    do_start(10'd2);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hD1);
    in_valid = 1'b0;
    wait_status("f_bad");
    check("f_bad_error", 32'(error), 1);
    check("f_bad_done", 32'(done), 0);
    check("f_bad_hold", 32'(cpu_hold), 1);
    check("f_bad_writes", 32'(writes - w0), 2);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
